id_ex_skid_stage: RTL
=====================

ID_EX_SKID_STAGE -- requirements
Module: id_ex_skid_stage

Interface
REQ-001 SHALL have parameter CTL_W, default 9, packed control width {wb[1:0], m[2:0], ex[3:0]}.
REQ-002 SHALL have parameter DATA_W, default 32, width of npc, rdata1, rdata2, sign-extend fields.
REQ-003 SHALL have parameter REG_W, default 5, width of rt (instr[20:16]) and rd (instr[15:11]) fields.
REQ-004 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-005 SHALL define PL_W = 4*DATA_W + 2*REG_W, packed {npc, rdata1, rdata2, sext, rt, rd}, npc at MSBs.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  synchronous squash of all held entries (branch/jump redirect).
REQ-009 in_valid  input  1  upstream (ID) entry present.
REQ-010 in_ready  output  1  stage can accept an entry this cycle; driven from a register.
REQ-011 ctl_in  input  CTL_W  ID control bundle.
REQ-012 data_in  input  PL_W  ID payload bundle.
REQ-013 out_valid  output  1  EX-side entry present.
REQ-014 out_ready  input  1  EX consumes entry this cycle.
REQ-015 ctl_out  output  CTL_W  held control bundle, gated to zero when out_valid=0.
REQ-016 data_out  output  PL_W  held payload bundle, ungated.
REQ-017 occupancy  output  2  number of held entries, 0..2.
REQ-018 stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-019 SHALL hold two entries: OUT (drives outputs) and SKID (overflow), each with a valid bit.
REQ-020 SHALL implement states EMPTY (none valid), ONE (OUT valid), TWO (OUT and SKID valid); occupancy SHALL equal 0/1/2 respectively.
REQ-021 Accept SHALL mean in_valid && in_ready at a rising edge; consume SHALL mean out_valid && out_ready.
REQ-022 EMPTY: accept -> ONE, OUT <= input; no accept -> EMPTY.
REQ-023 ONE: accept+consume -> ONE, OUT <= input; accept only -> TWO, SKID <= input; consume only -> EMPTY; neither -> ONE, hold.
REQ-024 TWO: consume -> ONE, OUT <= SKID; no consume -> TWO, hold; in_valid ignored.
REQ-025 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, updated registered with the state.
REQ-026 Latency SHALL be one cycle: entry accepted in EMPTY appears on out_valid/ctl_out/data_out at the next edge.
REQ-027 Order SHALL be preserved; no entry dropped or duplicated absent flush.
REQ-028 flush SHALL take priority over accept and consume: next state EMPTY, both valid bits 0, same-cycle input discarded, in_ready 1 next cycle.
REQ-029 Payload registers MAY retain stale values when invalid; ctl_out SHALL read 0 whenever out_valid=0 (bubble).
REQ-030 stall_cnt SHALL increment each cycle out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, be unaffected by flush.

Reset
REQ-031 reset=0 SHALL immediately force state EMPTY, both valid bits 0, all payload/control registers 0, stall_cnt 0, in_ready 1.
REQ-032 Reset asserted mid-transfer SHALL discard all held entries; first accept after release behaves as from EMPTY.

Verification
REQ-033 Reset then in_valid=1, ctl_in=9'h1A5, npc=32'h0000_0004, out_ready=1 -> next cycle out_valid=1, ctl_out=9'h1A5, occupancy=1.
REQ-034 Stream A,B,C each cycle with out_ready=1 -> outputs A,B,C on consecutive cycles, occupancy stays 1, stall_cnt=0.
REQ-035 Hold out_ready=0, send A then B -> occupancy=2, in_ready=0, C held off; raise out_ready -> A then B then C, stall_cnt=2 after first stalled pair of cycles as counted.
REQ-036 Occupancy=2 with flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, ctl_out=0, occupancy=0, in_ready=1, input lost.
REQ-037 out_valid=1, out_ready=0 for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt saturates at 15.
REQ-038 Assert reset=0 asynchronously between edges while occupancy=2 -> outputs zero immediately, in_ready=1, no entry emerges after release.

Source files
------------

// File: rtl/id_ex_skid_stage_if.sv
// ID/EX stage-boundary bundle: upstream valid/ready/control/payload plus the EX-side view.
// The stage uses the slave modport; the driving environment uses master.
interface id_ex_skid_stage_if #(
    parameter int CTL_W  = 9,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    localparam int PL_W = 4*DATA_W + 2*REG_W;

    logic              in_valid;
    logic              in_ready;
    logic [CTL_W-1:0]  ctl_in;
    logic [PL_W-1:0]   data_in;
    logic              out_valid;
    logic              out_ready;
    logic [CTL_W-1:0]  ctl_out;
    logic [PL_W-1:0]   data_out;

    modport slave (
        input  in_valid, ctl_in, data_in, out_ready,
        output in_ready, out_valid, ctl_out, data_out
    );

    modport master (
        output in_valid, ctl_in, data_in, out_ready,
        input  in_ready, out_valid, ctl_out, data_out
    );
endinterface

// File: rtl/id_ex_skid_stage.sv
// Two-entry ID/EX pipeline register with a skid slot, so in_ready can come straight from a
// flop while EX backpressure is absorbed without losing or reordering entries.
module id_ex_skid_stage #(
    parameter int CTL_W  = 9,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    id_ex_skid_stage_if.slave bus,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PL_W = 4*DATA_W + 2*REG_W;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q, state_nx;
    logic             out_vld_q, skid_vld_q;
    logic             in_ready_q;
    logic [CTL_W-1:0] out_ctl_q, skid_ctl_q;
    logic [PL_W-1:0]  out_data_q, skid_data_q;
    logic [CNT_W-1:0] stall_q;

    logic accept, consume;
    logic load_out_in, load_out_skid, load_skid_in;

    assign accept  = bus.in_valid && in_ready_q;
    assign consume = out_vld_q && bus.out_ready;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nx      = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid_in  = 1'b0;
        if (flush) begin
            state_nx = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_nx    = S_ONE;
                        load_out_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && consume) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_nx     = S_TWO;
                        load_skid_in = 1'b1;
                    end else if (consume) begin
                        state_nx = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (consume) begin
                        state_nx      = S_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nx = S_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nx;
            out_vld_q  <= (state_nx != S_EMPTY);
            skid_vld_q <= (state_nx == S_TWO);
            in_ready_q <= (state_nx != S_TWO);
        end
    end

    // NOTE: the payload registers are reset too, so outputs read zero during and right after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_ctl_q   <= '0;
            out_data_q  <= '0;
            skid_ctl_q  <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_out_in) begin
                out_ctl_q  <= bus.ctl_in;
                out_data_q <= bus.data_in;
            end else if (load_out_skid) begin
                out_ctl_q  <= skid_ctl_q;
                out_data_q <= skid_data_q;
            end
            if (load_skid_in) begin
                skid_ctl_q  <= bus.ctl_in;
                skid_data_q <= bus.data_in;
            end
        end
    end

    // Counts EX backpressure independently of flush; sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (out_vld_q && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_vld_q;
    assign bus.ctl_out   = out_vld_q ? out_ctl_q : '0;
    assign bus.data_out  = out_data_q;
    assign occupancy     = {skid_vld_q, out_vld_q && !skid_vld_q};
    assign stall_cnt     = stall_q;
endmodule
